// File: rtl/bq_sample_in.sv
// ---------------------------------------------------------------------------
// bq_sample_in
//   Input conditioning stage in front of the biquad core's sample input.
//   The asynchronous parallel pad bus is brought into the filter clock domain
//   through two flop stages. It is sampled on a programmable tick and
//   box-car averaged over 2^dec_sel samples. Each average is handed to the
//   core through a valid/ready register with a sticky overrun flag.
//
// Ports
//   bq_clk_i  in   filter clock, all state on the rising edge
//   nreset    in   asynchronous active-low reset
//   x_pad     in   [DW]    raw pad sample bus (async to bq_clk_i), signed
//   enable    in   run control; low discards any partial block
//   div       in   [DIV_W] tick period in clocks (0 behaves as 1)
//   dec_sel   in   [3]     decimation exponent, saturates at MAXLOG2
//   x_out     out  [DW]    averaged sample
//   x_valid   out  x_out holds an unconsumed sample
//   x_ready   in   consumer accepts x_out this cycle
//   overrun   out  sticky: an unconsumed sample was overwritten
//   clr_ovr   in   synchronous clear of overrun (a same-cycle set wins)
// ---------------------------------------------------------------------------
module bq_sample_in #(
  parameter int DW      = 12,
  parameter int DIV_W   = 16,
  parameter int MAXLOG2 = 4
) (
  input  logic             bq_clk_i,
  input  logic             nreset,
  input  logic [DW-1:0]    x_pad,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic [2:0]       dec_sel,
  output logic [DW-1:0]    x_out,
  output logic             x_valid,
  input  logic             x_ready,
  output logic             overrun,
  input  logic             clr_ovr
);

  // Accumulator is wide enough for 2^MAXLOG2 full-scale samples.
  localparam int         AW      = DW + MAXLOG2;
  // Block counter is one bit wider than needed, so the block length
  // 2^dec_lat is representable before subtracting one.
  localparam int         CW      = MAXLOG2 + 1;
  localparam logic [2:0] MAX_DEC = 3'(MAXLOG2);

  logic [DW-1:0]        sync1;
  logic [DW-1:0]        sx;
  logic [DIV_W-1:0]     div_cnt;
  logic [DIV_W-1:0]     period;
  logic                 tick;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        samp_cnt;
  logic [CW-1:0]        blk_last;
  logic [2:0]           dec_lat;
  logic [2:0]           dec_sat;
  logic                 blk_end;
  logic                 new_res;
  logic                 xfer;
  logic [DW-1:0]        result;

  // -------------------------------------------------------------------------
  // Pad synchroniser. The source holds the bus stable for several clocks
  // around each tick, so no per-bit skew correction is needed.
  // -------------------------------------------------------------------------
  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '0;
      sx    <= '0;
    end else begin
      sync1 <= x_pad;
      sx    <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Tick divider. The wrap uses >= so that shrinking div below the current
  // count wraps straight to 0 without producing a tick.
  // -------------------------------------------------------------------------
  assign period = (div == '0) ? DIV_W'(1) : div;
  assign tick   = enable && (div_cnt == period - DIV_W'(1));

  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else if (div_cnt >= period - DIV_W'(1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Box-car accumulator. dec_lat is only reloaded at a block boundary or
  // while stopped, so a dec_sel change never alters a block in progress.
  // -------------------------------------------------------------------------
  assign dec_sat  = (dec_sel > MAX_DEC) ? MAX_DEC : dec_sel;
  assign blk_last = (CW'(1) << dec_lat) - CW'(1);
  assign blk_end  = (samp_cnt == blk_last);
  assign sum      = acc + {{MAXLOG2{sx[DW-1]}}, sx};
  // Arithmetic shift floors toward -inf; the mean always fits back in DW.
  assign result   = DW'(sum >>> dec_lat);
  assign new_res  = tick && blk_end;

  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      acc      <= '0;
      samp_cnt <= '0;
      dec_lat  <= '0;
    end else if (!enable) begin
      acc      <= '0;
      samp_cnt <= '0;
      dec_lat  <= dec_sat;
    end else if (tick) begin
      if (blk_end) begin
        acc      <= '0;
        samp_cnt <= '0;
        dec_lat  <= dec_sat;
      end else begin
        acc      <= sum;
        samp_cnt <= samp_cnt + CW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register.
  // Handshake: x_out is transferred on every rising edge where x_valid and
  // x_ready are both high. x_out is stable while x_valid is high unless a
  // transfer or a new result occurs. A new result always loads; if it lands
  // on a pending sample that is not being taken this cycle, overrun sets.
  // A pending sample survives enable going low.
  // -------------------------------------------------------------------------
  assign xfer = x_valid && x_ready;

  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      x_out   <= '0;
      x_valid <= 1'b0;
    end else if (new_res) begin
      x_out   <= result;
      x_valid <= 1'b1;
    end else if (xfer) begin
      x_valid <= 1'b0;
    end
  end

  always_ff @(posedge bq_clk_i or negedge nreset) begin
    if (!nreset) begin
      overrun <= 1'b0;
    end else if (new_res && x_valid && !x_ready) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bq_sample_in.sv
// ---------------------------------------------------------------------------
// tb_bq_sample_in
//   Self-checking bench for bq_sample_in. Stimulus tasks drive the pad bus
//   and control inputs on the falling edge. Expected averages are computed
//   from the driven samples and queued; a monitor pops and compares them on
//   every valid/ready transfer. Direct checks cover reset, latency, overrun
//   and x_valid cadence.
// ---------------------------------------------------------------------------
module tb_bq_sample_in;

  logic        clk;
  logic        nreset;
  logic [11:0] x_pad;
  logic        enable;
  logic [15:0] div;
  logic [2:0]  dec_sel;
  logic [11:0] x_out;
  logic        x_valid;
  logic        x_ready;
  logic        overrun;
  logic        clr_ovr;

  logic [11:0] exp_q[$];
  int          vq[$];
  logic [11:0] smp[0:39];
  int          n_cmp;
  int          n_err;
  int          cyc;

  bq_sample_in #(.DW(12), .DIV_W(16), .MAXLOG2(4)) dut (
    .bq_clk_i (clk),
    .nreset   (nreset),
    .x_pad    (x_pad),
    .enable   (enable),
    .div      (div),
    .dec_sel  (dec_sel),
    .x_out    (x_out),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  // -------------------------------------------------------------------------
  // Clock and watchdog
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Checker
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Floor-mean of cnt signed samples starting at smp[first].
  function automatic logic [11:0] avg(input int first, input int cnt);
    int s;
    int q;
    s = 0;
    for (int i = first; i < first + cnt; i++) s += int'($signed(smp[i]));
    q = s / cnt;
    if ((s % cnt != 0) && (s < 0)) q -= 1;
    return 12'(q);
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard monitor: samples 1 time unit before each rising edge.
  // -------------------------------------------------------------------------
  always begin
    @(negedge clk);
    #4;
    cyc++;
    if (nreset && x_valid) vq.push_back(cyc);
    if (nreset && x_valid && x_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("x_out", 32'(x_out), 32'(exp_q.pop_front()));
    end
  end

  // -------------------------------------------------------------------------
  // Drivers
  // -------------------------------------------------------------------------
  // Streams smp[0..n-1], each held for max(d,1) clocks. enable rises two
  // clocks after the first sample is on the pad so the synchroniser is
  // filled; tick k then lands exactly on sample k. drop_at pulls enable low
  // for one iteration; chg_at switches dec_sel to chg_dec.
  task automatic stream(input int d, input int n, input int drop_at,
                        input int chg_at, input logic [2:0] chg_dec);
    int step;
    int idx;
    step = (d == 0) ? 1 : d;
    div  = 16'(d);
    for (int c = 0; c < 2 + n * step; c++) begin
      @(negedge clk);
      idx = c / step;
      if (idx > n - 1) idx = n - 1;
      x_pad  = smp[idx];
      enable = (c >= 2) && (c != drop_at);
      if (c == chg_at) dec_sel = chg_dec;
    end
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    nreset  = 1'b0;
    enable  = 1'b0;
    x_pad   = '0;
    div     = 16'd1;
    dec_sel = 3'd0;
    x_ready = 1'b1;
    clr_ovr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Pass-through, back-to-back results with transfer on every cycle.
    dec_sel = 3'd0;
    smp[0] = 12'h123; smp[1] = 12'h7FF; smp[2] = 12'h800;
    for (int i = 0; i < 3; i++) exp_q.push_back(smp[i]);
    vq.delete();
    stream(1, 3, -1, -1, 3'd0);
    drain();
    chk("pt_valid_cnt", 32'(vq.size()), 32'd3);
    if (vq.size() == 3) chk("pt_valid_run", 32'(vq[2] - vq[0]), 32'd2);
    chk("pt_overrun", 32'(overrun), 32'd0);

    // Pad-to-x_out latency: 2 sync stages plus the output register.
    x_ready = 1'b0;
    div     = 16'd1;
    x_pad   = 12'h100;
    @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    x_pad = 12'h2AB;
    @(negedge clk);
    @(negedge clk);
    chk("lat_2clk", 32'(x_out), 32'h100);
    @(negedge clk);
    chk("lat_3clk", 32'(x_out), 32'h2AB);
    enable  = 1'b0;
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("lat_clr_ovr", 32'(overrun), 32'd0);
    exp_q.push_back(12'h2AB);
    x_ready = 1'b1;
    drain();

    // Averaging over 4 samples at div=4, incl. floor of a negative mean.
    dec_sel = 3'd2;
    smp[0] = 12'h064; smp[1] = 12'h065; smp[2] = 12'hFCE; smp[3] = 12'hFCC;
    smp[4] = 12'hFFF; smp[5] = 12'hFFF; smp[6] = 12'hFFF; smp[7] = 12'hFFE;
    exp_q.push_back(12'h018);
    exp_q.push_back(12'hFFE);
    vq.delete();
    stream(4, 8, -1, -1, 3'd0);
    drain();
    chk("avg_valid_cnt", 32'(vq.size()), 32'd2);
    if (vq.size() == 2) chk("avg_valid_gap", 32'(vq[1] - vq[0]), 32'd16);

    // Backpressure: three results with no consumer.
    dec_sel = 3'd0;
    x_ready = 1'b0;
    smp[0] = 12'h0A1; smp[1] = 12'h0B2; smp[2] = 12'h0C3;
    stream(2, 3, -1, -1, 3'd0);
    chk("bp_x_out", 32'(x_out), 32'h0C3);
    chk("bp_x_valid", 32'(x_valid), 32'd1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("bp_clr", 32'(overrun), 32'd0);
    chk("bp_hold", 32'(x_out), 32'h0C3);
    // clr_ovr held across another overwrite: the set must win.
    smp[0]  = 12'h0D4;
    clr_ovr = 1'b1;
    stream(2, 1, -1, -1, 3'd0);
    chk("bp_set_wins", 32'(overrun), 32'd1);
    chk("bp_x_out2", 32'(x_out), 32'h0D4);
    clr_ovr = 1'b0;
    exp_q.push_back(12'h0D4);
    x_ready = 1'b1;
    drain();
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;

    // dec_sel 0 -> 3 mid-stream: three singles, then one 8-sample block.
    dec_sel = 3'd0;
    for (int i = 0; i < 11; i++) smp[i] = 12'($urandom_range(0, 4095));
    for (int i = 0; i < 3; i++) exp_q.push_back(smp[i]);
    exp_q.push_back(avg(3, 8));
    stream(1, 11, -1, 4, 3'd3);
    drain();

    // dec_sel=7 saturates to 16-sample blocks.
    dec_sel = 3'd7;
    for (int i = 0; i < 32; i++) smp[i] = 12'($urandom_range(0, 4095));
    exp_q.push_back(avg(0, 16));
    exp_q.push_back(avg(16, 16));
    stream(1, 32, -1, -1, 3'd0);
    drain();

    // One-clock enable drop mid-block: partial sum discarded.
    dec_sel = 3'd2;
    smp[0] = 12'h7FF; smp[1] = 12'h7FF;
    for (int i = 2; i < 7; i++) smp[i] = 12'($urandom_range(0, 4095));
    exp_q.push_back(avg(3, 4));
    stream(1, 7, 4, -1, 3'd0);
    drain();
    chk("drop_overrun", 32'(overrun), 32'd0);

    // div=0 ticks every clock like div=1.
    dec_sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      smp[i] = 12'($urandom_range(0, 4095));
      exp_q.push_back(smp[i]);
    end
    stream(0, 3, -1, -1, 3'd0);
    drain();

    // Asynchronous reset mid-block with a pending sample and overrun set.
    x_ready = 1'b0;
    dec_sel = 3'd0;
    smp[0] = 12'h111; smp[1] = 12'h222;
    stream(1, 2, -1, -1, 3'd0);
    chk("pre_rst_valid", 32'(x_valid), 32'd1);
    chk("pre_rst_overrun", 32'(overrun), 32'd1);
    dec_sel = 3'd2;
    div     = 16'd1;
    enable  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("arst_x_out", 32'(x_out), 32'd0);
    chk("arst_x_valid", 32'(x_valid), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    nreset  = 1'b1;
    x_ready = 1'b1;
    for (int i = 0; i < 4; i++) smp[i] = 12'($urandom_range(0, 4095));
    exp_q.push_back(avg(0, 4));
    stream(1, 4, -1, -1, 3'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
